// File: rtl/cga_idbctl_pkg.sv
// Shared types and constants for the IDB source arbiter.
// Optional round-robin arbitration is enabled with CGA_IDBCTL_RR_EN.
package cga_idbctl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StTurn
    } idb_state_e;

    localparam int unsigned NUM_SRC = 6;

    localparam logic [2:0] SRC_D   = 3'd5;
    localparam logic [2:0] SRC_M   = 3'd4;
    localparam logic [2:0] SRC_V   = 3'd3;
    localparam logic [2:0] SRC_S   = 3'd2;
    localparam logic [2:0] SRC_PCR = 3'd1;
    localparam logic [2:0] SRC_PGS = 3'd0;

    // Round-robin search begins one below the last owner, wrapping 0 -> 5.
    function automatic logic [2:0] rr_start(input logic [2:0] last);
        return (last == SRC_PGS) ? SRC_D : (last - 3'd1);
    endfunction

endpackage

// File: rtl/cga_idbctl_pick6.sv
// Combinational 6-way picker: descending search from start_i with wraparound.
module cga_idbctl_pick6
    import cga_idbctl_pkg::*;
(
    input  logic [5:0] req_i,
    input  logic [2:0] start_i,
    output logic [5:0] grant_o,
    output logic [2:0] idx_o
);

    logic        found;
    int unsigned pos;
    logic [2:0]  cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pos  = (32'(start_i) + NUM_SRC - i) % NUM_SRC;
            cand = pos[2:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/cga_idbctl_src_arb.sv
// IDB source arbiter/sequencer: one-hot registered enables, turnaround gap, bounded tenure.
// Define CGA_IDBCTL_RR_EN for round-robin; otherwise fixed priority (D highest).
module cga_idbctl_src_arb
    import cga_idbctl_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic       sysclk,
    input  logic       sys_rst,
    input  logic [5:0] req,
    output logic [5:0] e_pins,
    output logic [2:0] owner,
    output logic       busy,
    output logic       preempt
);

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
    localparam logic [1:0] TurnLast = 2'(TURN_CYC - 1);

    idb_state_e state_q, state_d;
    logic [5:0] e_pins_q, e_pins_d;
    logic [2:0] owner_q, owner_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] turn_q, turn_d;
    logic [5:0] excl_q, excl_d;
    logic       preempt_q, preempt_d;

    logic [5:0] masked_req;
    logic [5:0] pick_req;
    logic [2:0] start_idx;
    logic [5:0] win_onehot;
    logic [2:0] win_idx;

    assign masked_req = req & ~excl_q;
    // An excluded requester still wins when nobody else is asking.
    assign pick_req   = (masked_req != 6'd0) ? masked_req : req;

`ifdef CGA_IDBCTL_RR_EN
    logic [2:0] last_q, last_d;
    assign start_idx = rr_start(last_q);
`else
    assign start_idx = SRC_D;
`endif

    cga_idbctl_pick6 u_pick (
        .req_i   (pick_req),
        .start_i (start_idx),
        .grant_o (win_onehot),
        .idx_o   (win_idx)
    );

    always_comb begin
        state_d   = state_q;
        e_pins_d  = e_pins_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        excl_d    = excl_q;
        preempt_d = 1'b0;
`ifdef CGA_IDBCTL_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (req != 6'd0) begin
                    state_d  = StGrant;
                    e_pins_d = win_onehot;
                    owner_d  = win_idx;
                    hold_d   = 8'd0;
                    excl_d   = 6'd0;
`ifdef CGA_IDBCTL_RR_EN
                    last_d   = win_idx;
`endif
                end
            end
            StGrant: begin
                if ((req & e_pins_q) == 6'd0) begin
                    state_d  = StTurn;
                    e_pins_d = 6'd0;
                    turn_d   = 2'd0;
                end else if (hold_q == HoldLast && (req & ~e_pins_q) != 6'd0) begin
                    state_d   = StTurn;
                    e_pins_d  = 6'd0;
                    turn_d    = 2'd0;
                    preempt_d = 1'b1;
                    excl_d    = e_pins_q;
                end else if (hold_q != HoldLast) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            StTurn: begin
                if (turn_q == TurnLast) begin
                    state_d = StIdle;
                end else begin
                    turn_d = turn_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            e_pins_q  <= 6'd0;
            owner_q   <= 3'd0;
            hold_q    <= 8'd0;
            turn_q    <= 2'd0;
            excl_q    <= 6'd0;
            preempt_q <= 1'b0;
`ifdef CGA_IDBCTL_RR_EN
            last_q    <= SRC_PGS;
`endif
        end else begin
            state_q   <= state_d;
            e_pins_q  <= e_pins_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            excl_q    <= excl_d;
            preempt_q <= preempt_d;
`ifdef CGA_IDBCTL_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign e_pins  = e_pins_q;
    assign owner   = owner_q;
    assign busy    = (e_pins_q != 6'd0);
    assign preempt = preempt_q;

endmodule

// File: tb/tb_cga_idbctl_src_arb.sv
// Scoreboard bench for cga_idbctl_src_arb: tenure-level reference model feeds an expected
// queue, a negedge monitor pops and compares.
module tb_cga_idbctl_src_arb;

    localparam int unsigned MaxHold = 8;
    localparam int unsigned TurnCyc = 1;

    logic       sysclk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [5:0] req = 6'h3f;
    logic [5:0] e_pins;
    logic [2:0] owner;
    logic       busy;
    logic       preempt;

    typedef struct packed {
        logic [5:0] en;
        logic [2:0] own;
        logic       chk_own;
        logic       pre;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    cga_idbctl_src_arb #(
        .MAX_HOLD (MaxHold),
        .TURN_CYC (TurnCyc)
    ) dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .req     (req),
        .e_pins  (e_pins),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 sysclk = ~sysclk;

    // ---------------- reference model (tenure-oriented) ----------------
    int         last_owner = 0;
    logic [5:0] excl = 6'd0;

    task automatic sample(output logic [5:0] rq, output logic rs);
        @(posedge sysclk);
        rq = req;
        rs = sys_rst;
    endtask

    task automatic push(input logic [5:0] en, input int own, input logic chk, input logic pre);
        exp_t e;
        e.en      = en;
        e.own     = 3'(own);
        e.chk_own = chk;
        e.pre     = pre;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        last_owner = 0;
        excl       = 6'd0;
        push(6'd0, 0, 1'b1, 1'b0);
    endtask

    function automatic int choose(input logic [5:0] rq);
        logic [5:0] pool;
        int         idx;
        pool = ((rq & ~excl) != 6'd0) ? (rq & ~excl) : rq;
`ifdef CGA_IDBCTL_RR_EN
        for (int k = 1; k <= 6; k++) begin
            idx = (last_owner + 6 - k) % 6;
            if (pool[idx]) return idx;
        end
`else
        for (idx = 5; idx >= 0; idx--) begin
            if (pool[idx]) return idx;
        end
`endif
        return 0;
    endfunction

    initial begin : model
        logic [5:0] rq;
        logic       rs;
        logic [5:0] oh;
        int         w;
        int         held;
        logic       forced;
        logic       aborted;
        forever begin
            sample(rq, rs);
            if (rs) begin
                model_reset();
                continue;
            end
            if (rq == 6'd0) begin
                push(6'd0, 0, 1'b0, 1'b0);
                continue;
            end
            w          = choose(rq);
            oh         = 6'd1 << w;
            excl       = 6'd0;
            last_owner = w;
            push(oh, w, 1'b1, 1'b0);
            held    = 1;
            forced  = 1'b0;
            aborted = 1'b0;
            forever begin
                sample(rq, rs);
                if (rs) begin
                    model_reset();
                    aborted = 1'b1;
                    break;
                end
                if (!rq[w]) break;
                if (held >= int'(MaxHold) && (rq & ~oh) != 6'd0) begin
                    forced = 1'b1;
                    excl   = oh;
                    break;
                end
                held++;
                push(oh, w, 1'b1, 1'b0);
            end
            if (aborted) continue;
            push(6'd0, 0, 1'b0, forced);
            for (int k = 1; k <= int'(TurnCyc); k++) begin
                sample(rq, rs);
                if (rs) begin
                    model_reset();
                    aborted = 1'b1;
                    break;
                end
                push(6'd0, 0, 1'b0, 1'b0);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        logic bad;
        forever begin
            @(negedge sysclk);
            cyc++;
            vectors++;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow cyc=%0d: no expected entry for DUT output", cyc);
                miscompares++;
                continue;
            end
            e   = exp_q.pop_front();
            bad = 1'b0;
            if (e_pins !== e.en) begin
                $display("FAIL e_pins cyc=%0d got=%b exp=%b", cyc, e_pins, e.en);
                bad = 1'b1;
            end
            if (busy !== (e.en != 6'd0)) begin
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (e.en != 6'd0));
                bad = 1'b1;
            end
            if (preempt !== e.pre) begin
                $display("FAIL preempt cyc=%0d got=%b exp=%b", cyc, preempt, e.pre);
                bad = 1'b1;
            end
            if (e.chk_own && owner !== e.own) begin
                $display("FAIL owner cyc=%0d got=%0d exp=%0d", cyc, owner, e.own);
                bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic ncyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin : stim
        // Reset with every requester asking; first grant must be D.
        ncyc(3);
        sys_rst = 1'b0;
        ncyc(20);
        // Single PCR requester.
        req = 6'd0; sys_rst = 1'b1; ncyc(1);
        sys_rst = 1'b0; req = 6'b000010; ncyc(5);
        req = 6'd0; ncyc(5);
        // Continuous D/PGS contention: forced releases alternate owners.
        req = 6'b100001; ncyc(40);
        // Owner drops exactly when tenure expires: no preempt.
        req = 6'd0; sys_rst = 1'b1; ncyc(1);
        sys_rst = 1'b0; req = 6'b100001; ncyc(int'(MaxHold));
        req = 6'b000001; ncyc(20);
        // Reset pulse mid-grant, request held throughout.
        req = 6'd0; sys_rst = 1'b1; ncyc(1);
        sys_rst = 1'b0; req = 6'b001000; ncyc(3);
        sys_rst = 1'b1; ncyc(1);
        sys_rst = 1'b0; ncyc(6);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 99) == 0) req = 6'd0;
            sys_rst = ($urandom_range(0, 299) == 0);
            ncyc(1);
        end
        sys_rst = 1'b0;
        req = 6'd0;
        ncyc(10);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
